apb_gpio_ext: RTL and testbench
===============================

# apb_gpio_ext

Parametrised APB GPIO controller: the next generation of the fixed 8-bit GPIO core on the processor subsystem's APB peripheral bus. It provides a runtime-programmable register file in place of build-time FIXED_CONFIG/IO_INT_TYPE constants, and adds:
- 1 to 32 pins;
- atomic set/clear of outputs;
- per-pin output enable;
- input synchronisation with a programmable debounce filter;
- per-pin interrupt mode with write-1-to-clear status.

## Interface
- IO_NUM, 8, number of pins, 1..32
- DEB_WIDTH, 16, width of the debounce prescaler register
- OUT_RESET, 32'h0, reset value of DATA_OUT, bits [IO_NUM-1:0] used
- OE_RESET, 32'h0, reset value of OE register

Ports:
- PCLK  in  1  sole clock
- PRESET  in  1  synchronous, active-high reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable
- PWRITE  in  1  APB write
- PADDR  in  8  byte address, bits [1:0] ignored
- PWDATA  in  32  write data
- PRDATA  out  32  read data
- PREADY  out  1  tied 1
- PSLVERR  out  1  unmapped-address error
- GPIO_IN  in  IO_NUM  asynchronous pad inputs
- GPIO_OUT  out  IO_NUM  output data
- GPIO_OE  out  IO_NUM  output enables
- INT  out  IO_NUM  per-pin interrupt, IRQ_STATUS & IRQ_EN
- INT_OR  out  1  OR of INT

## Operation
Register map (word offsets). Bits at or above IO_NUM read 0 and ignore writes.
- 0x00 DATA_OUT, RW
- 0x04 SET, write-only: DATA_OUT |= PWDATA
- 0x08 CLR, write-only: DATA_OUT &= ~PWDATA
- 0x0C OE, RW
- 0x10 DATA_IN, RO, filtered inputs
- 0x14 IRQ_EN, RW
- 0x18 IRQ_STATUS, read / write-1-to-clear
- 0x1C IRQ_EDGE, RW: 0 = level, 1 = edge
- 0x20 IRQ_POL, RW: 0 = low/falling, 1 = high/rising
- 0x24 IRQ_BOTH, RW: 1 = both edges, overrides POL when EDGE = 1
- 0x28 DEBOUNCE, RW, DEB_WIDTH bits; 0 = filter bypass

Accesses and PSLVERR:
- Write/read of any other offset: PSLVERR = 1 during the access phase, PRDATA = 0, no state change.
- Reads of SET/CLR return 0 with no error.

Input path:
- Two-flop synchroniser per pin.
- Filter stage, DEBOUNCE = 0: filt <= sync every cycle.
- Filter stage, DEBOUNCE = N > 0: a shared prescaler counts 0..N and emits a one-cycle tick at N, then wraps to 0.
  - On each tick, each pin shifts sync into a 2-bit history.
  - filt takes the sample value when the current sample and both history bits agree, i.e. 3 consecutive equal ticks.
- Writing DEBOUNCE clears the prescaler and all histories. filt holds its value.

Interrupt set condition, per pin:
- Level mode: filt == POL.
- Edge mode: selected transition of filt versus filt_d, its previous-cycle value.
- Status bit sets on the condition and holds until cleared by W1C.
- Set has priority over a W1C clear in the same cycle, so a level source that is still active re-asserts immediately.
- Changing IRQ_EDGE/POL/BOTH does not clear status.

## Timing
Reset, PRESET sampled high at a PCLK edge:
- DATA_OUT = OUT_RESET, OE = OE_RESET.
- IRQ_EN, IRQ_STATUS, EDGE, POL, BOTH, DEBOUNCE = 0.
- Synchronisers, filt, filt_d, histories and prescaler = 0.
- Outputs: GPIO_OUT = OUT_RESET[IO_NUM-1:0], GPIO_OE = OE_RESET[IO_NUM-1:0], INT = 0, INT_OR = 0, PRDATA = 0, PSLVERR = 0.
- A reset asserted mid-transfer aborts the transfer with no register update.

APB:
- Zero wait states.
- Write commits at the PCLK edge ending the cycle where PSEL & PENABLE & PWRITE.
- GPIO_OUT/GPIO_OE change the following cycle, as registered outputs.
- PRDATA and PSLVERR are combinational from PADDR and the registers while PSEL & PENABLE, and 0 otherwise.

Input latency, bypass, pad change sampled at edge k:
- sync valid after edge k+1.
- filt / DATA_IN after edge k+2.
- IRQ_STATUS and INT after edge k+3.
- INT_OR is combinational from INT.

With DEBOUNCE = N, a filt change requires 3 ticks, i.e. at most 3(N+1)+2 cycles after the pad change.

## Structure
- Package apb_gpio_ext_pkg: register offset localparams, EDGE/POL encoding constants, max IO_NUM = 32.
- Sub-module gpio_debounce holds the per-pin state and is generated IO_NUM times:
  - inputs: sync, tick, clear
  - state: synchroniser, history, filt
- The top level holds the APB decode, registers, shared prescaler, edge detect and status.

## Test plan
- Reset value and write/read: after reset, read 0x00 -> OUT_RESET, 0x0C -> OE_RESET. Write DATA_OUT = 0xA5, SET 0x0F, CLR 0x80 -> GPIO_OUT = 0x2F one cycle after the last write. Access to 0x2C -> PSLVERR = 1, no change.
- Rising-edge IRQ, bypass: EDGE = 0x01, POL = 0x01, IRQ_EN = 0x01; GPIO_IN[0] 0 -> 1 -> INT[0] and INT_OR high exactly 3 cycles later. W1C 0x01 -> both low next cycle, and stay low while the pin remains high.
- Level-low IRQ with clear collision: EDGE = 0, POL = 0, pin held 0. W1C in the same cycle as the set condition -> status remains 1. Release the pin to 1, then W1C -> INT clears.
- Both-edge IRQ: BOTH = 0x04, EDGE = 0x04; toggle pin 2 up, clear, toggle down -> status bit 2 sets on each transition.
- Debounce: DEBOUNCE = 4; glitch GPIO_IN[3] high for 6 cycles -> DATA_IN[3] stays 0. Hold high -> DATA_IN[3] = 1 within 17 cycles.
- Reset mid-write: assert PRESET in the access cycle of a DATA_OUT = 0xFF write -> DATA_OUT = OUT_RESET, and all status and INT = 0.

Source files
------------

// File: rtl/apb_gpio_ext_pkg.sv
// rtl/apb_gpio_ext_pkg.sv - register map and encoding constants for apb_gpio_ext
package apb_gpio_ext_pkg;

    localparam int MAX_IO_NUM = 32;

    // Byte offsets of the register file; PADDR[1:0] never take part in decode.
    localparam logic [7:0] ADDR_DATA_OUT   = 8'h00;
    localparam logic [7:0] ADDR_SET        = 8'h04;
    localparam logic [7:0] ADDR_CLR        = 8'h08;
    localparam logic [7:0] ADDR_OE         = 8'h0C;
    localparam logic [7:0] ADDR_DATA_IN    = 8'h10;
    localparam logic [7:0] ADDR_IRQ_EN     = 8'h14;
    localparam logic [7:0] ADDR_IRQ_STATUS = 8'h18;
    localparam logic [7:0] ADDR_IRQ_EDGE   = 8'h1C;
    localparam logic [7:0] ADDR_IRQ_POL    = 8'h20;
    localparam logic [7:0] ADDR_IRQ_BOTH   = 8'h24;
    localparam logic [7:0] ADDR_DEBOUNCE   = 8'h28;

    localparam logic EDGE_LEVEL = 1'b0;
    localparam logic EDGE_EDGE  = 1'b1;
    localparam logic POL_LOW    = 1'b0;
    localparam logic POL_HIGH   = 1'b1;

endpackage

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - per-pin two-flop synchroniser and 3-tick debounce filter
//
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   pad      : asynchronous pad input
//   bypass   : 1 = filt follows the synchronised input every cycle
//   tick     : shared prescaler tick, shifts the sample history
//   clear    : clears the history (filt keeps its value)
//   filt     : filtered input level
module gpio_debounce (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    input  logic bypass,
    input  logic tick,
    input  logic clear,
    output logic filt
);

    logic       meta;
    logic       sync;
    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            hist <= 2'b00;
            filt <= 1'b0;
        end else begin
            meta <= pad;
            sync <= meta;
            if (clear) begin
                hist <= 2'b00;
            end else if (bypass) begin
                filt <= sync;
            end else if (tick) begin
                hist <= {hist[0], sync};
                // Current sample plus two older ticks must all agree.
                if (sync == hist[0] && sync == hist[1]) begin
                    filt <= sync;
                end
            end
        end
    end

endmodule

// File: rtl/apb_gpio_ext.sv
// rtl/apb_gpio_ext.sv - parametrised APB GPIO controller with debounce and per-pin interrupts
//
// Ports:
//   PCLK, PRESET                     : clock, synchronous active-high reset
//   PSEL, PENABLE, PWRITE, PADDR,
//   PWDATA, PRDATA, PREADY, PSLVERR  : zero-wait-state APB slave
//   GPIO_IN                          : asynchronous pad inputs
//   GPIO_OUT, GPIO_OE                : registered output data and enables
//   INT, INT_OR                      : per-pin interrupts and their OR
module apb_gpio_ext
    import apb_gpio_ext_pkg::*;
#(
    parameter int          IO_NUM    = 8,
    parameter int          DEB_WIDTH = 16,
    parameter logic [31:0] OUT_RESET = 32'h0,
    parameter logic [31:0] OE_RESET  = 32'h0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [7:0]        PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [IO_NUM-1:0] GPIO_IN,
    output logic [IO_NUM-1:0] GPIO_OUT,
    output logic [IO_NUM-1:0] GPIO_OE,
    output logic [IO_NUM-1:0] INT,
    output logic              INT_OR
);

    logic [IO_NUM-1:0]    data_out, oe, irq_en, irq_status;
    logic [IO_NUM-1:0]    irq_edge, irq_pol, irq_both;
    logic [IO_NUM-1:0]    filt, filt_d, irq_set, w1c;
    logic [DEB_WIDTH-1:0] debounce, presc;
    logic [7:0]           addr;
    logic                 access, wr, mapped, tick, bypass, deb_clear;
    logic [31:0]          rd;
    logic                 unused_ok;

    assign unused_ok = ^{PADDR[1:0], PWDATA};

    assign addr      = {PADDR[7:2], 2'b00};
    assign access    = PSEL & PENABLE;
    assign wr        = access & PWRITE;
    assign bypass    = (debounce == '0);
    assign tick      = !bypass && (presc == debounce);
    assign deb_clear = wr && (addr == ADDR_DEBOUNCE);
    assign w1c       = (wr && addr == ADDR_IRQ_STATUS) ? PWDATA[IO_NUM-1:0] : '0;

    for (genvar i = 0; i < IO_NUM; i++) begin : g_pin
        gpio_debounce u_deb (
            .clk    (PCLK),
            .rst    (PRESET),
            .pad    (GPIO_IN[i]),
            .bypass (bypass),
            .tick   (tick),
            .clear  (deb_clear),
            .filt   (filt[i])
        );
    end

    always_comb begin
        irq_set = '0;
        for (int i = 0; i < IO_NUM; i++) begin
            if (irq_edge[i] == EDGE_LEVEL) begin
                irq_set[i] = (filt[i] == irq_pol[i]);
            end else if (irq_both[i]) begin
                irq_set[i] = filt[i] ^ filt_d[i];
            end else if (irq_pol[i] == POL_HIGH) begin
                irq_set[i] = filt[i] & ~filt_d[i];
            end else begin
                irq_set[i] = ~filt[i] & filt_d[i];
            end
        end
    end

    always_comb begin
        rd     = '0;
        mapped = 1'b1;
        case (addr)
            ADDR_DATA_OUT:   rd[IO_NUM-1:0] = data_out;
            ADDR_SET:        rd = '0;
            ADDR_CLR:        rd = '0;
            ADDR_OE:         rd[IO_NUM-1:0] = oe;
            ADDR_DATA_IN:    rd[IO_NUM-1:0] = filt;
            ADDR_IRQ_EN:     rd[IO_NUM-1:0] = irq_en;
            ADDR_IRQ_STATUS: rd[IO_NUM-1:0] = irq_status;
            ADDR_IRQ_EDGE:   rd[IO_NUM-1:0] = irq_edge;
            ADDR_IRQ_POL:    rd[IO_NUM-1:0] = irq_pol;
            ADDR_IRQ_BOTH:   rd[IO_NUM-1:0] = irq_both;
            ADDR_DEBOUNCE:   rd[DEB_WIDTH-1:0] = debounce;
            default:         mapped = 1'b0;
        endcase
    end

    assign PRDATA  = (access && mapped) ? rd : '0;
    assign PSLVERR = access & ~mapped;
    assign PREADY  = 1'b1;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            data_out   <= OUT_RESET[IO_NUM-1:0];
            oe         <= OE_RESET[IO_NUM-1:0];
            irq_en     <= '0;
            irq_status <= '0;
            irq_edge   <= '0;
            irq_pol    <= '0;
            irq_both   <= '0;
            debounce   <= '0;
            presc      <= '0;
            filt_d     <= '0;
        end else begin
            filt_d     <= filt;
            // A live set condition wins over a simultaneous W1C.
            irq_status <= (irq_status & ~w1c) | irq_set;

            if (deb_clear || bypass || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end

            if (wr) begin
                case (addr)
                    ADDR_DATA_OUT: data_out <= PWDATA[IO_NUM-1:0];
                    ADDR_SET:      data_out <= data_out | PWDATA[IO_NUM-1:0];
                    ADDR_CLR:      data_out <= data_out & ~PWDATA[IO_NUM-1:0];
                    ADDR_OE:       oe       <= PWDATA[IO_NUM-1:0];
                    ADDR_IRQ_EN:   irq_en   <= PWDATA[IO_NUM-1:0];
                    ADDR_IRQ_EDGE: irq_edge <= PWDATA[IO_NUM-1:0];
                    ADDR_IRQ_POL:  irq_pol  <= PWDATA[IO_NUM-1:0];
                    ADDR_IRQ_BOTH: irq_both <= PWDATA[IO_NUM-1:0];
                    ADDR_DEBOUNCE: debounce <= PWDATA[DEB_WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign GPIO_OUT = data_out;
    assign GPIO_OE  = oe;
    assign INT      = irq_status & irq_en;
    assign INT_OR   = |INT;

endmodule

// File: tb/tb_apb_gpio_ext.sv
// tb/tb_apb_gpio_ext.sv - self-checking bench for apb_gpio_ext
module tb_apb_gpio_ext;

    localparam int IO_NUM = 8;

    logic              PCLK = 1'b0;
    logic              PRESET, PSEL, PENABLE, PWRITE;
    logic [7:0]        PADDR;
    logic [31:0]       PWDATA, PRDATA;
    logic              PREADY, PSLVERR;
    logic [IO_NUM-1:0] GPIO_IN, GPIO_OUT, GPIO_OE, INT;
    logic              INT_OR;

    apb_gpio_ext #(
        .IO_NUM    (IO_NUM),
        .DEB_WIDTH (16),
        .OUT_RESET (32'h0000_005A),
        .OE_RESET  (32'h0000_00C3)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .GPIO_IN (GPIO_IN),
        .GPIO_OUT(GPIO_OUT),
        .GPIO_OE (GPIO_OE),
        .INT     (INT),
        .INT_OR  (INT_OR)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [7:0]  exp_out;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2 err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2 d = PRDATA; err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    logic [31:0] d;
    logic        e;
    int          c0, lat;
    logic        got;

    initial begin
        vecs[0]  = '{1'b0, 8'h00, 32'h0,         32'h5A,   1'b0, 8'h5A};
        vecs[1]  = '{1'b0, 8'h0C, 32'h0,         32'hC3,   1'b0, 8'h5A};
        vecs[2]  = '{1'b0, 8'h18, 32'h0,         32'hFF,   1'b0, 8'h5A};
        vecs[3]  = '{1'b1, 8'h00, 32'hA5,        32'h0,    1'b0, 8'hA5};
        vecs[4]  = '{1'b1, 8'h04, 32'h0F,        32'h0,    1'b0, 8'hAF};
        vecs[5]  = '{1'b1, 8'h08, 32'h80,        32'h0,    1'b0, 8'h2F};
        vecs[6]  = '{1'b0, 8'h00, 32'h0,         32'h2F,   1'b0, 8'h2F};
        vecs[7]  = '{1'b0, 8'h04, 32'h0,         32'h0,    1'b0, 8'h2F};
        vecs[8]  = '{1'b0, 8'h08, 32'h0,         32'h0,    1'b0, 8'h2F};
        vecs[9]  = '{1'b1, 8'h2C, 32'hFFFF_FFFF, 32'h0,    1'b1, 8'h2F};
        vecs[10] = '{1'b0, 8'h2C, 32'h0,         32'h0,    1'b1, 8'h2F};
        vecs[11] = '{1'b0, 8'h00, 32'h0,         32'h2F,   1'b0, 8'h2F};
        vecs[12] = '{1'b1, 8'h0C, 32'h1FF,       32'h0,    1'b0, 8'h2F};
        vecs[13] = '{1'b0, 8'h0C, 32'h0,         32'hFF,   1'b0, 8'h2F};
        vecs[14] = '{1'b1, 8'h28, 32'h12345,     32'h0,    1'b0, 8'h2F};
        vecs[15] = '{1'b0, 8'h28, 32'h0,         32'h2345, 1'b0, 8'h2F};
        vecs[16] = '{1'b1, 8'h28, 32'h0,         32'h0,    1'b0, 8'h2F};
        vecs[17] = '{1'b0, 8'h30, 32'h0,         32'h0,    1'b1, 8'h2F};

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; GPIO_IN = '0;
        wait_cycles(2);
        PRESET = 1'b0;

        check("reset_gpio_out", GPIO_OUT, 32'h5A);
        check("reset_gpio_oe", GPIO_OE, 32'hC3);
        check("reset_int", INT, 32'h0);
        check("reset_int_or", INT_OR, 32'h0);
        check("reset_prdata", PRDATA, 32'h0);
        check("reset_pslverr", PSLVERR, 32'h0);
        check("pready", PREADY, 32'h1);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].wdata, e);
            end else begin
                apb_read(vecs[i].addr, d, e);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rd);
            end
            check($sformatf("vec%0d_pslverr", i), e, vecs[i].exp_err);
            check($sformatf("vec%0d_gpio_out", i), GPIO_OUT, vecs[i].exp_out);
        end
        check("oe_after_write", GPIO_OE, 32'hFF);

        // Rising edge on pin 0, bypass filter
        apb_write(8'h1C, 32'h01, e);
        apb_write(8'h20, 32'h01, e);
        apb_write(8'h18, 32'hFF, e);
        apb_write(8'h14, 32'h01, e);
        check("rise_int_idle", INT, 32'h0);
        GPIO_IN[0] = 1'b1;
        wait_cycles(3);
        check("rise_int_early", INT, 32'h0);
        wait_cycles(1);
        check("rise_int_set", INT, 32'h01);
        check("rise_int_or_set", INT_OR, 32'h1);
        apb_write(8'h18, 32'h01, e);
        check("rise_int_w1c", INT, 32'h0);
        check("rise_int_or_w1c", INT_OR, 32'h0);
        wait_cycles(5);
        check("rise_int_stays_low", INT, 32'h0);
        apb_read(8'h10, d, e);
        check("rise_data_in", d, 32'h01);

        // Level-low on pin 1 with W1C collision
        apb_write(8'h1C, 32'h00, e);
        apb_write(8'h20, 32'h00, e);
        apb_write(8'h14, 32'h02, e);
        check("lvl_int_active", INT, 32'h02);
        apb_write(8'h18, 32'h02, e);
        check("lvl_int_collide", INT, 32'h02);
        apb_read(8'h18, d, e);
        check("lvl_status_bit1", d & 32'h02, 32'h02);
        GPIO_IN[1] = 1'b1;
        wait_cycles(5);
        check("lvl_int_held", INT, 32'h02);
        apb_write(8'h18, 32'h02, e);
        check("lvl_int_cleared", INT, 32'h0);
        check("lvl_int_or_cleared", INT_OR, 32'h0);

        // Both edges on pin 2
        apb_write(8'h24, 32'h04, e);
        apb_write(8'h1C, 32'h04, e);
        apb_write(8'h18, 32'hFF, e);
        apb_write(8'h14, 32'h04, e);
        check("both_int_idle", INT, 32'h0);
        GPIO_IN[2] = 1'b1;
        wait_cycles(4);
        check("both_int_rise", INT, 32'h04);
        apb_write(8'h18, 32'h04, e);
        check("both_int_w1c1", INT, 32'h0);
        wait_cycles(3);
        check("both_int_quiet", INT, 32'h0);
        GPIO_IN[2] = 1'b0;
        wait_cycles(4);
        check("both_int_fall", INT, 32'h04);
        apb_write(8'h18, 32'h04, e);
        check("both_int_w1c2", INT, 32'h0);

        // Debounce N=4 on pin 3
        apb_write(8'h28, 32'h4, e);
        GPIO_IN[3] = 1'b1;
        wait_cycles(6);
        GPIO_IN[3] = 1'b0;
        wait_cycles(25);
        apb_read(8'h10, d, e);
        check("deb_glitch_rejected", d, 32'h03);
        GPIO_IN[3] = 1'b1;
        c0 = cyc;
        wait_cycles(8);
        apb_read(8'h10, d, e);
        check("deb_not_yet", d & 32'h08, 32'h0);
        got = 1'b0;
        lat = 0;
        while (!got && (cyc - c0) < 40) begin
            apb_read(8'h10, d, e);
            if (d[3]) begin
                got = 1'b1;
                lat = cyc - c0;
            end
        end
        check("deb_hold_seen", got, 32'h1);
        check("deb_latency_max", (lat <= 21), 32'h1);
        check("deb_latency_min", (lat >= 12), 32'h1);
        check("deb_data_in", d, 32'h0B);

        // Reset during the access phase of a DATA_OUT write
        apb_write(8'h14, 32'hFF, e);
        check("rst_pre_int", INT & 32'hF0, 32'hF0);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'hFF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1; PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        check("rst_gpio_out", GPIO_OUT, 32'h5A);
        check("rst_gpio_oe", GPIO_OE, 32'hC3);
        check("rst_int", INT, 32'h0);
        check("rst_int_or", INT_OR, 32'h0);
        apb_read(8'h00, d, e);
        check("rst_data_out", d, 32'h5A);
        apb_read(8'h28, d, e);
        check("rst_debounce", d, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
